// File: rtl/micro_op_sequencer.sv
// Sequencer for PDP-8 style operate (OPR) micro-instructions: accepts one word,
// hands latched state to an external decoder and writes results back 3 cycles later.
module micro_op_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [11:0] instr,
    input  logic [11:0] instr_pc,
    output logic        instr_ready,
    output logic [11:0] dec_i_reg,
    output logic [11:0] dec_ac,
    output logic        dec_l,
    input  logic [11:0] ac_micro,
    input  logic        l_micro,
    input  logic        skip,
    input  logic        micro_g1,
    input  logic        micro_g2,
    input  logic        micro_g3,
    input  logic        ac_wr_en,
    input  logic [11:0] ac_wr_data,
    input  logic        l_wr_data,
    input  logic [11:0] switch_reg,
    input  logic        cont,
    output logic [11:0] ac,
    output logic        link,
    output logic [11:0] next_pc,
    output logic        done,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_HALTED} state_t;

    state_t      state_q;
    logic [11:0] i_q, pc_q, lac_q;
    logic        ll_q;
    logic [11:0] ac_h_q;
    logic        l_h_q, skip_h_q;
    logic [2:0]  grp_h_q;
    logic [11:0] ac_q, next_pc_q;
    logic        link_q, done_q, illegal_q, halted_q;

    logic [11:0] ac_d, next_pc_d;
    logic        link_d, g1_sel, g2_sel;

    // Group flags are expected one-hot; any other combination behaves as a NOP.
    assign g1_sel = (grp_h_q == 3'b100);
    assign g2_sel = (grp_h_q == 3'b010);

    always_comb begin
        ac_d   = ac_q;
        link_d = link_q;
        if (g1_sel) begin
            ac_d   = ac_h_q;
            link_d = l_h_q;
        end else if (g2_sel) begin
            ac_d   = i_q[2] ? (ac_h_q | switch_reg) : ac_h_q;
            link_d = l_h_q;
        end
        next_pc_d = pc_q + ((g2_sel && skip_h_q) ? 12'd2 : 12'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            pc_q      <= '0;
            lac_q     <= '0;
            ll_q      <= 1'b0;
            ac_h_q    <= '0;
            l_h_q     <= 1'b0;
            skip_h_q  <= 1'b0;
            grp_h_q   <= '0;
            ac_q      <= '0;
            link_q    <= 1'b0;
            next_pc_q <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Acceptance wins over an external AC load in the same cycle.
                    if (instr_valid) begin
                        i_q   <= instr;
                        pc_q  <= instr_pc;
                        lac_q <= ac_q;
                        ll_q  <= link_q;
                        if (instr[11:9] == 3'b111) begin
                            state_q <= S_EXEC;
                        end else begin
                            illegal_q <= 1'b1;
                            done_q    <= 1'b1;
                        end
                    end else if (ac_wr_en) begin
                        ac_q   <= ac_wr_data;
                        link_q <= l_wr_data;
                    end
                end
                S_EXEC: begin
                    ac_h_q   <= ac_micro;
                    l_h_q    <= l_micro;
                    skip_h_q <= skip;
                    grp_h_q  <= {micro_g1, micro_g2, micro_g3};
                    state_q  <= S_WB;
                end
                S_WB: begin
                    ac_q      <= ac_d;
                    link_q    <= link_d;
                    next_pc_q <= next_pc_d;
                    done_q    <= 1'b1;
                    if (g2_sel && i_q[1]) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HALTED: begin
                    if (cont) begin
                        state_q  <= S_IDLE;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign dec_i_reg   = i_q;
    assign dec_ac      = lac_q;
    assign dec_l       = ll_q;
    assign ac          = ac_q;
    assign link        = link_q;
    assign next_pc     = next_pc_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_micro_op_sequencer.sv
// Directed bench for micro_op_sequencer; the decoder is played by hand-computed
// values driven during EXEC.
module tb_micro_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [11:0] instr = '0, instr_pc = '0;
    logic        instr_ready;
    logic [11:0] dec_i_reg, dec_ac;
    logic        dec_l;
    logic [11:0] ac_micro = '0;
    logic        l_micro = 1'b0, skip = 1'b0;
    logic        micro_g1 = 1'b0, micro_g2 = 1'b0, micro_g3 = 1'b0;
    logic        ac_wr_en = 1'b0;
    logic [11:0] ac_wr_data = '0;
    logic        l_wr_data = 1'b0;
    logic [11:0] switch_reg = '0;
    logic        cont = 1'b0;
    logic [11:0] ac, next_pc;
    logic        link, done, illegal, halted;

    int checks = 0;
    int failures = 0;

    micro_op_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .dec_i_reg(dec_i_reg), .dec_ac(dec_ac), .dec_l(dec_l),
        .ac_micro(ac_micro), .l_micro(l_micro), .skip(skip),
        .micro_g1(micro_g1), .micro_g2(micro_g2), .micro_g3(micro_g3),
        .ac_wr_en(ac_wr_en), .ac_wr_data(ac_wr_data), .l_wr_data(l_wr_data),
        .switch_reg(switch_reg), .cont(cont),
        .ac(ac), .link(link), .next_pc(next_pc),
        .done(done), .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic load_ac(input logic [11:0] v, input logic l);
        ac_wr_en = 1'b1; ac_wr_data = v; l_wr_data = l;
        tick();
        ac_wr_en = 1'b0;
        chk("load_ac", ac, v);
        chk("load_link", {11'd0, link}, {11'd0, l});
    endtask

    task automatic set_dec(input logic [11:0] a, input logic l, input logic s, input logic [2:0] g);
        ac_micro = a; l_micro = l; skip = s;
        {micro_g1, micro_g2, micro_g3} = g;
    endtask

    // Accept an OPR word, feed the decoder in EXEC, check the N+3 writeback.
    task automatic run_opr(input string tag, input logic [11:0] iw, input logic [11:0] pc,
                           input logic [11:0] ea, input logic el, input logic [11:0] eac,
                           input logic el2, input logic es, input logic [2:0] g,
                           input logic [11:0] exp_ac, input logic exp_l, input logic [11:0] exp_pc);
        instr_valid = 1'b1; instr = iw; instr_pc = pc;
        tick();
        instr_valid = 1'b0;
        chk({tag, "_dec_i"}, dec_i_reg, iw);
        chk({tag, "_dec_ac"}, dec_ac, ea);
        chk({tag, "_dec_l"}, {11'd0, dec_l}, {11'd0, el});
        chk({tag, "_done_n1"}, {11'd0, done}, 12'd0);
        set_dec(eac, el2, es, g);
        tick();
        set_dec(12'o0, 1'b0, 1'b0, 3'b000);
        chk({tag, "_done_n2"}, {11'd0, done}, 12'd0);
        chk({tag, "_ready_n2"}, {11'd0, instr_ready}, 12'd0);
        tick();
        chk({tag, "_done_n3"}, {11'd0, done}, 12'd1);
        chk({tag, "_ac"}, ac, exp_ac);
        chk({tag, "_link"}, {11'd0, link}, {11'd0, exp_l});
        chk({tag, "_next_pc"}, next_pc, exp_pc);
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_ac", ac, 12'o0);
        chk("rst_npc", next_pc, 12'o0);
        chk("rst_flags", {8'd0, link, done, illegal, halted}, 12'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", {11'd0, instr_ready}, 12'd1);

        // CLA CLL CMA
        load_ac(12'o1234, 1'b1);
        run_opr("cla_cma", 12'o7340, 12'o0100, 12'o1234, 1'b1, 12'o7777, 1'b0, 1'b0, 3'b100,
                12'o7777, 1'b0, 12'o0101);
        chk("cla_ready_n3", {11'd0, instr_ready}, 12'd1);
        tick();
        chk("cla_done_n4", {11'd0, done}, 12'd0);

        // SZA with skip wrapping past 7777, then without skip
        load_ac(12'o0000, 1'b0);
        run_opr("sza_skip", 12'o7440, 12'o7777, 12'o0000, 1'b0, 12'o0000, 1'b0, 1'b1, 3'b010,
                12'o0000, 1'b0, 12'o0001);
        tick();
        load_ac(12'o0005, 1'b0);
        run_opr("sza_noskip", 12'o7440, 12'o7777, 12'o0005, 1'b0, 12'o0005, 1'b0, 1'b0, 3'b010,
                12'o0005, 1'b0, 12'o0000);
        tick();

        // OSR
        load_ac(12'o0012, 1'b0);
        switch_reg = 12'o0400;
        run_opr("osr", 12'o7404, 12'o0200, 12'o0012, 1'b0, 12'o0012, 1'b0, 1'b0, 3'b010,
                12'o0412, 1'b0, 12'o0201);
        tick();
        switch_reg = 12'o0;

        // Non-OPR instruction
        instr_valid = 1'b1; instr = 12'o1234; instr_pc = 12'o0300;
        tick();
        instr_valid = 1'b0;
        chk("ill_illegal", {11'd0, illegal}, 12'd1);
        chk("ill_done", {11'd0, done}, 12'd1);
        chk("ill_ac", ac, 12'o0412);
        chk("ill_npc", next_pc, 12'o0201);
        chk("ill_ready", {11'd0, instr_ready}, 12'd1);
        tick();
        chk("ill_pulse_end", {10'd0, illegal, done}, 12'd0);

        // Acceptance beats a same-cycle load; valid and load ignored while busy
        instr_valid = 1'b1; instr = 12'o7200; instr_pc = 12'o0500;
        ac_wr_en = 1'b1; ac_wr_data = 12'o7000; l_wr_data = 1'b1;
        tick();
        instr = 12'o1111;
        chk("prio_dec_ac", dec_ac, 12'o0412);
        chk("prio_ac_kept", ac, 12'o0412);
        set_dec(12'o0000, 1'b0, 1'b0, 3'b100);
        tick();
        set_dec(12'o0000, 1'b0, 1'b0, 3'b000);
        chk("busy_dec_i", dec_i_reg, 12'o7200);
        chk("busy_illegal", {11'd0, illegal}, 12'd0);
        chk("busy_ac", ac, 12'o0412);
        tick();
        instr_valid = 1'b0; ac_wr_en = 1'b0;
        chk("prio_done", {11'd0, done}, 12'd1);
        chk("prio_illegal", {11'd0, illegal}, 12'd0);
        chk("prio_ac", ac, 12'o0000);
        chk("prio_link", {11'd0, link}, 12'd0);
        chk("prio_npc", next_pc, 12'o0501);
        tick();

        // HLT, then cont
        run_opr("hlt", 12'o7402, 12'o0400, 12'o0000, 1'b0, 12'o0000, 1'b0, 1'b0, 3'b010,
                12'o0000, 1'b0, 12'o0401);
        chk("hlt_halted", {11'd0, halted}, 12'd1);
        chk("hlt_ready", {11'd0, instr_ready}, 12'd0);
        instr_valid = 1'b1; instr = 12'o7200;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hlt_hold", {10'd0, halted, instr_ready}, 12'b10);
        end
        chk("hlt_no_done", {11'd0, done}, 12'd0);
        instr_valid = 1'b0;
        cont = 1'b1;
        tick();
        cont = 1'b0;
        chk("cont_halted", {11'd0, halted}, 12'd0);
        chk("cont_ready", {11'd0, instr_ready}, 12'd1);

        // Reset while in EXEC
        load_ac(12'o0005, 1'b0);
        instr_valid = 1'b1; instr = 12'o7001; instr_pc = 12'o0600;
        tick();
        instr_valid = 1'b0;
        set_dec(12'o0006, 1'b0, 1'b0, 3'b100);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ac", ac, 12'o0000);
        chk("mid_rst_dec", dec_i_reg, 12'o0000);
        tick();
        set_dec(12'o0000, 1'b0, 1'b0, 3'b000);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {11'd0, instr_ready}, 12'd1);
        chk("post_rst_done", {11'd0, done}, 12'd0);
        tick();
        chk("post_rst_done2", {11'd0, done}, 12'd0);
        chk("post_rst_ac", ac, 12'o0000);
        chk("post_rst_npc", next_pc, 12'o0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/micro_op_sequencer.md
MICRO_OP_SEQUENCER -- requirements
Module: micro_op_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
REQ-002 SHALL have these instruction ports:
- instr_valid  input  1  instruction offered
- instr  input  12  instruction word
- instr_pc  input  12  address of the offered instruction
- instr_ready  output  1  high only in IDLE
REQ-003 SHALL have these decoder ports:
- dec_i_reg  output  12  latched instruction to the decoder
- dec_ac  output  12  latched AC to the decoder
- dec_l  output  1  latched link to the decoder
- ac_micro  input  12  decoder AC result
- l_micro  input  1  decoder link result
- skip  input  1  decoder skip result
- micro_g1, micro_g2, micro_g3  input  1 each  decoder group flags
REQ-004 SHALL have these datapath and control ports:
- ac_wr_en  input  1  external AC/link load, honoured in IDLE only
- ac_wr_data  input  12  AC load value
- l_wr_data  input  1  link load value
- switch_reg  input  12  front-panel switch register
- cont  input  1  leave HALTED
- ac  output  12  accumulator
- link  output  1  link
- next_pc  output  12  PC following the completed instruction
- done  output  1  one-cycle completion pulse
- illegal  output  1  one-cycle pulse, non-OPR instruction
- halted  output  1  HALTED state indicator

Function
REQ-005 SHALL implement the states IDLE, EXEC, WB and HALTED.
REQ-006 SHALL accept an instruction in IDLE when instr_valid && instr_ready (cycle N), latching instr, instr_pc, ac and link, and move to EXEC.
REQ-007 SHALL, when instr[11:9] != 3'b111 at acceptance, stay in IDLE, pulse illegal and done in cycle N+1, and leave ac, link and next_pc unchanged.
REQ-008 SHALL hold dec_i_reg, dec_ac and dec_l constant from the latched values from EXEC through WB.
REQ-009 SHALL, in EXEC (cycle N+1), capture ac_micro, l_micro, skip and the group flags into holding registers, then move to WB.
REQ-010 SHALL, in WB (cycle N+2), register the results as follows:
- micro_g1: ac=ac_micro, link=l_micro
- micro_g2: ac=ac_micro, or ac_micro|switch_reg when latched instr[2] (OSR) = 1; link=l_micro
- micro_g3: ac and link unchanged (NOP)
REQ-011 SHALL set next_pc=instr_pc+2 when micro_g2 && skip, else next_pc=instr_pc+1, computed modulo 4096 (7777+1=0000, 7777+2=0001).
REQ-012 SHALL pulse done for exactly one cycle (cycle N+3), coincident with the updated ac, link and next_pc, giving a fixed 3-cycle latency.
REQ-013 SHALL leave WB for HALTED when micro_g2 && latched instr[1] (HLT) = 1, otherwise for IDLE; done SHALL still pulse on HLT.
REQ-014 SHALL hold halted=1 and instr_ready=0 in HALTED, and return to IDLE on the cycle after cont=1.
REQ-015 SHALL load ac=ac_wr_data and link=l_wr_data on ac_wr_en in IDLE; ac_wr_en SHALL be ignored in other states.
REQ-016 SHALL give acceptance priority over ac_wr_en when both occur in the same IDLE cycle: the load is dropped and the old ac is latched.
REQ-017 SHALL ignore instr_valid outside IDLE and accept no back-to-back instructions; the earliest next acceptance is cycle N+3.

Reset
REQ-018 SHALL, while rst=1 (asynchronously), force:
- state=IDLE
- ac=0, link=0, next_pc=0
- done=0, illegal=0, halted=0
- holding and latched registers=0
REQ-019 SHALL abandon any in-flight instruction on reset with no done pulse and no register update; instr_ready SHALL be 1 on the first cycle after release.

Verification
REQ-020 SHALL cover CLA CLL CMA: ac=1234, link=1, instr=7340, pc=0100 -> N+3: done=1, ac=7777, link=0, next_pc=0101.
REQ-021 SHALL cover SZA skip with wrap: ac=0000, instr=7440, pc=7777 -> next_pc=0001, ac=0000; with ac=0005 -> next_pc=0000.
REQ-022 SHALL cover OSR: ac=0012, switch_reg=0400, instr=7404 -> ac=0412, next_pc=pc+1.
REQ-023 SHALL cover HLT: instr=7402 -> done pulse, then halted=1 and instr_ready=0 for 10 cycles; cont pulse -> next cycle halted=0, instr_ready=1.
REQ-024 SHALL cover a non-OPR instruction: instr=1234 -> N+1: illegal=1, done=1, ac/link/next_pc unchanged, instr_ready stays 1.
REQ-025 SHALL cover reset mid-operation: rst asserted in EXEC of 7001 with ac=0005 -> ac=0 immediately, no done pulse, instr_ready=1 after release.
